// File: rtl/uart_core.sv
`timescale 1ns/1ps
// uart_core: full-duplex UART with a baud-tick generator, a TX FIFO, a TX shifter
// and a 16x-oversampling receiver with false-start rejection and error pulses.
//
// Optional feature macro: UART_PARITY_EN
//   defined   -> a parity bit follows the data on TX and is checked on RX
//                (even parity, or odd when PARITY_ODD=1)
//   undefined -> no parity state exists; rx_parity_err is tied to 0
//
// Parameters: DATA_BITS (5..9), FIFO_DEPTH (power of 2, >= 2), PARITY_ODD (0/1)
// Ports:
//   clk, reset (async, active-low)
//   baud_div      - one tick every baud_div+1 clocks; 16 ticks per bit
//   tx_data/tx_valid/tx_ready - FIFO write handshake
//   tx_busy       - shifter active or FIFO non-empty
//   tx_count      - FIFO occupancy
//   txd           - serial output, idles high
//   rxd           - asynchronous serial input
//   rx_data/rx_valid          - last good word and its one-cycle strobe
//   rx_frame_err/rx_parity_err - one-cycle error strobes
module uart_core #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [15:0]                   baud_div,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   tx_count,
   output logic                          txd,
   input  logic                          rxd,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   output logic                          rx_frame_err,
   output logic                          rx_parity_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // ---------------- tick generator ----------------
   // The divisor is latched at each reload so a new baud_div only applies
   // from the next reload.
   logic [15:0] r_tick_cnt;
   logic [15:0] r_div;
   logic        w_tick;

   assign w_tick = (r_tick_cnt == r_div);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick_cnt <= '0;
         r_div      <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
         r_div      <= baud_div;
      end else begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic                 w_push, w_tx_pop, w_fifo_empty, w_tx_ready;
   logic [DATA_BITS-1:0] w_head;

   assign w_tx_ready   = (r_count != CW'(FIFO_DEPTH));
   assign w_fifo_empty = (r_count == '0);
   assign w_push       = tx_valid && w_tx_ready;
   assign w_head       = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_tx_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_tx_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_tx_pop) r_count <= r_count - CW'(1);
      end
   end

   // ---------------- TX state machine ----------------
   state_t               r_tx_state, w_tx_next;
   logic [3:0]           r_tx_sub;
   logic [3:0]           r_tx_bit;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_txd;
   logic                 w_tx_bit_end, w_tx_last;
`ifdef UART_PARITY_EN
   logic                 r_tx_par;
`endif

   assign w_tx_bit_end = w_tick && (r_tx_sub == 4'd15);
   assign w_tx_last    = (r_tx_bit == 4'(DATA_BITS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_tx_state <= S_IDLE;
      else        r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_pop  = 1'b0;
      case (r_tx_state)
         S_IDLE: if (w_tick && !w_fifo_empty) begin
            w_tx_pop  = 1'b1;
            w_tx_next = S_START;
         end
         S_START: if (w_tx_bit_end) w_tx_next = S_DATA;
`ifdef UART_PARITY_EN
         S_DATA:   if (w_tx_bit_end && w_tx_last) w_tx_next = S_PARITY;
         S_PARITY: if (w_tx_bit_end) w_tx_next = S_STOP;
`else
         S_DATA:   if (w_tx_bit_end && w_tx_last) w_tx_next = S_STOP;
`endif
         S_STOP: if (w_tx_bit_end) begin
            // back-to-back frames: the stop-ending tick also starts the next word
            if (!w_fifo_empty) begin
               w_tx_pop  = 1'b1;
               w_tx_next = S_START;
            end else begin
               w_tx_next = S_IDLE;
            end
         end
         default: w_tx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tx_sub   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
`ifdef UART_PARITY_EN
         r_tx_par   <= 1'b0;
`endif
      end else if (w_tx_pop) begin
         r_tx_shift <= w_head;
         r_tx_sub   <= '0;
         r_txd      <= 1'b0;
`ifdef UART_PARITY_EN
         r_tx_par   <= (^w_head) ^ 1'(PARITY_ODD);
`endif
      end else if (w_tick && (r_tx_state != S_IDLE)) begin
         r_tx_sub <= r_tx_sub + 4'd1;
         if (r_tx_sub == 4'd15) begin
            case (r_tx_state)
               S_START: begin
                  r_txd    <= r_tx_shift[0];
                  r_tx_bit <= '0;
               end
               S_DATA: begin
                  if (w_tx_last) begin
`ifdef UART_PARITY_EN
                     r_txd <= r_tx_par;
`else
                     r_txd <= 1'b1;
`endif
                  end else begin
                     r_tx_shift <= r_tx_shift >> 1;
                     r_txd      <= r_tx_shift[1];
                     r_tx_bit   <= r_tx_bit + 4'd1;
                  end
               end
               default: r_txd <= 1'b1;
            endcase
         end
      end
   end

   // ---------------- RX synchroniser and state machine ----------------
   logic                 r_rx_s1, r_rx_s2, r_rx_prev;
   logic                 w_rx_line, w_rx_fall;
   state_t               r_rx_state, w_rx_next;
   logic [3:0]           r_rx_sub;
   logic [3:0]           r_rx_bit;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid, r_rx_ferr;
   logic                 w_rx_mid, w_rx_end, w_rx_last, w_rx_done, w_par_bad;
`ifdef UART_PARITY_EN
   logic                 r_rx_par_bit, r_rx_perr;
`endif

   assign w_rx_line = r_rx_s2;
   assign w_rx_fall = r_rx_prev && !r_rx_s2;
   assign w_rx_mid  = w_tick && (r_rx_sub == 4'd7);
   assign w_rx_end  = w_tick && (r_rx_sub == 4'd15);
   assign w_rx_last = (r_rx_bit == 4'(DATA_BITS - 1));
   assign w_rx_done = (r_rx_state == S_STOP) && w_rx_mid;
`ifdef UART_PARITY_EN
   assign w_par_bad = ((^r_rx_shift) ^ r_rx_par_bit) != 1'(PARITY_ODD);
`else
   assign w_par_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= S_IDLE;
      end else begin
         r_rx_s1    <= rxd;
         r_rx_s2    <= r_rx_s1;
         r_rx_prev  <= r_rx_s2;
         r_rx_state <= w_rx_next;
      end
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
         S_START: begin
            if (w_rx_mid && w_rx_line) w_rx_next = S_IDLE;   // false start
            else if (w_rx_end)         w_rx_next = S_DATA;
         end
`ifdef UART_PARITY_EN
         S_DATA:   if (w_rx_end && w_rx_last) w_rx_next = S_PARITY;
         S_PARITY: if (w_rx_end) w_rx_next = S_STOP;
`else
         S_DATA:   if (w_rx_end && w_rx_last) w_rx_next = S_STOP;
`endif
         // leaving at mid-stop re-arms edge detection for the next start bit
         S_STOP:  if (w_rx_mid) w_rx_next = S_IDLE;
         default: w_rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_sub     <= '0;
         r_rx_bit     <= '0;
         r_rx_shift   <= '0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_ferr    <= 1'b0;
`ifdef UART_PARITY_EN
         r_rx_par_bit <= 1'b0;
         r_rx_perr    <= 1'b0;
`endif
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
         r_rx_perr  <= 1'b0;
`endif
         if (r_rx_state == S_IDLE) begin
            r_rx_sub <= '0;
            r_rx_bit <= '0;
         end else if (w_tick) begin
            r_rx_sub <= r_rx_sub + 4'd1;
            if (w_rx_mid && (r_rx_state == S_DATA))
               r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
            if (w_rx_mid && (r_rx_state == S_PARITY))
               r_rx_par_bit <= w_rx_line;
`endif
            if (w_rx_end && (r_rx_state == S_DATA))
               r_rx_bit <= r_rx_bit + 4'd1;
         end
         if (w_rx_done) begin
            r_rx_ferr <= !w_rx_line;
`ifdef UART_PARITY_EN
            r_rx_perr <= w_par_bad;
`endif
            if (w_rx_line && !w_par_bad) begin
               r_rx_data  <= r_rx_shift;
               r_rx_valid <= 1'b1;
            end
         end
      end
   end

   assign tx_ready     = w_tx_ready;
   assign tx_busy      = (r_tx_state != S_IDLE) || !w_fifo_empty;
   assign tx_count     = r_count;
   assign txd          = r_txd;
   assign rx_data      = r_rx_data;
   assign rx_valid     = r_rx_valid;
   assign rx_frame_err = r_rx_ferr;
`ifdef UART_PARITY_EN
   assign rx_parity_err = r_rx_perr;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART core: baud-tick generator, transmit FIFO, transmit shifter and 16x-oversampling receiver. It is the next-generation replacement for the fixed-format `uart` top. Data width, FIFO depth and parity handling are configurable, and the core adds false-start rejection and error reporting. It sits between the bus-side register block (parallel `tx_*`/`rx_*` handshakes) and the chip pads (`txd`/`rxd`).

## Interface
- `DATA_BITS`, default 8 — frame data width, legal range 5..9.
- `FIFO_DEPTH`, default 4 — TX FIFO entries; must be a power of 2, at least 2.
- `PARITY_ODD`, default 0 — 0 selects even parity, 1 selects odd. Only used when the parity macro is defined.
- `clk` in 1 — single clock domain.
- `reset` in 1 — asynchronous, active-low; all state is cleared while it is low.
- `baud_div` in 16 — one baud tick every `baud_div+1` clocks.
- `tx_data` in DATA_BITS — word to transmit.
- `tx_valid` in 1 — write request.
- `tx_ready` out 1 — FIFO not full.
- `tx_busy` out 1 — shifter not idle, or FIFO not empty.
- `tx_count` out $clog2(FIFO_DEPTH)+1 — FIFO occupancy.
- `txd` out 1 — serial out; idle level is 1.
- `rxd` in 1 — serial in, asynchronous.
- `rx_data` out DATA_BITS — last good received word.
- `rx_valid` out 1 — one-cycle pulse when a new `rx_data` is available.
- `rx_frame_err` out 1 — one-cycle pulse when the stop bit is sampled as 0.
- `rx_parity_err` out 1 — one-cycle pulse on parity mismatch; tied to 0 when the parity macro is not defined.

## Operation
- **Reset values:** `txd`=1; `tx_ready`=1; `tx_busy`=0; `tx_count`=0; `rx_data`=0; `rx_valid`, `rx_frame_err`, `rx_parity_err` all 0. The FIFO is emptied, both state machines go to IDLE, and the tick counter is set to 0.
- **Tick generator:** a 16-bit counter increments every clock. When it equals `baud_div` it pulses `tick` for one cycle and reloads to 0. A new `baud_div` value takes effect at the next reload.
- **TX FIFO:**
  - A write occurs when `tx_valid && tx_ready`; `tx_valid` while full is ignored and the word is dropped.
  - A push and a pop in the same cycle leave `tx_count` unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **TX state machine:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - In IDLE, on a `tick` with the FIFO non-empty, the head word is popped into the shifter and the machine enters START.
  - Each bit lasts 16 ticks. Data is sent LSB first.
  - PARITY is skipped when the parity macro is not defined.
  - At the end of STOP the machine enters IDLE, or goes directly to START if the FIFO is non-empty and a tick arrives.
- **RX path:** `rxd` passes through a 2-flop synchroniser; all RX logic uses the synchronised value. RX state machine: IDLE → START → DATA → PARITY → STOP → IDLE.
  - A 1→0 transition in IDLE enters START and clears the tick sub-counter.
  - At sub-tick 7 of START, if the line is 1 it is a false start: the machine returns to IDLE with no output.
  - Otherwise DATA, PARITY and STOP are each sampled at sub-tick 7 of their 16-tick bit period.
- **Completion at the STOP sample:**
  - Stop bit = 0: pulse `rx_frame_err`.
  - Parity mismatch: pulse `rx_parity_err`.
  - Both errors: both pulses in the same cycle.
  - No error: load `rx_data` and pulse `rx_valid`.
  - `rx_data` is not updated on any error. The machine returns to IDLE, which re-arms the receiver in the second half of the stop bit.
- **Reset mid-frame:** `txd` returns to 1 immediately and asynchronously, the partial RX word is discarded, and no pulses are generated.

## Timing
- `tx_ready` = (`tx_count` != FIFO_DEPTH). It is combinational from registered state.
- `tx_count` updates on the clock edge after the push or pop.
- Frame length is 16 × (2 + DATA_BITS + P) ticks, where P = 1 if parity is enabled and 0 otherwise.
- `txd` is registered and changes on the clock after the tick that starts each bit.
- `rx_valid`, `rx_frame_err` and `rx_parity_err` are registered and assert on the clock after the stop-bit sampling tick, for exactly one cycle.
- `baud_div`=0 gives a tick every clock: 16 clocks per bit.

## Configuration
- `UART_PARITY_EN` defined:
  - A parity bit is inserted after the data on TX (even, or odd when `PARITY_ODD`=1).
  - The parity bit is checked on RX.
  - `rx_parity_err` is live.
- `UART_PARITY_EN` undefined:
  - No parity state exists in either state machine.
  - `rx_parity_err` is tied to 0.

## Test plan
- **TX serialisation:** DATA_BITS=8, no parity, `baud_div`=0, write 0xA5 → `txd` = 0, 1,0,1,0,0,1,0,1, 1; each bit held for 16 clocks; `tx_busy` falls after the stop bit.
- **FIFO full:** FIFO_DEPTH=4, `baud_div`=100; write 5 words on consecutive cycles immediately after reset release → `tx_count`=4, `tx_ready`=0 from the 4th write; the 5th word is dropped; the four words then appear on `txd` in write order.
- **Loopback:** `txd` tied to `rxd`, `baud_div`=3; send 0x3C then 0xC3 → two `rx_valid` pulses with `rx_data`=0x3C and then 0xC3; no error pulses.
- **False start and frame error:**
  - Drive `rxd` low for 4 ticks → no output pulses.
  - Drive a frame of 0x55 with stop bit = 0 → one `rx_frame_err` pulse; `rx_valid`=0; `rx_data` unchanged.
- **Parity** (`UART_PARITY_EN`, even parity):
  - TX of 0x07 → parity bit 1.
  - RX of 0x07 with parity bit 0 → `rx_parity_err` pulse, no `rx_valid`.
- **Reset mid-frame:** assert `reset` low during the DATA bits of TX and RX → `txd`=1 and `tx_count`=0 immediately; after release, no `rx_valid` for the aborted frame.
